// File: rtl/mips_alu_top_if.sv
// Operand/result bundle for the registered MIPS ALU.
// The overflow signal exists only when ALU_OVERFLOW_EN is defined.
interface mips_alu_top_if #(
  parameter int unsigned WIDTH = 32
);
  logic [5:0]       opcode;
  logic [5:0]       func_field;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef ALU_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output opcode, func_field, A, B,
    input  result, zero
`ifdef ALU_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  opcode, func_field, A, B,
    output result, zero
`ifdef ALU_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/mips_alu_top.sv
// Registered MIPS EX-stage ALU: opcode/func decode, ALU core, output register.
// Optional ALU_OVERFLOW_EN adds a registered signed-overflow flag.
module mips_alu_top #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mips_alu_top_if.slave bus
);
  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlXor  = 4'b0011;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlSlt  = 4'b0111;
  localparam logic [3:0] CtrlSltu = 4'b1000;
  localparam logic [3:0] CtrlNor  = 4'b1100;
  localparam logic [3:0] CtrlNop  = 4'b1111;

  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_q;

  always_comb begin
    alu_ctrl = CtrlNop;
    if (bus.opcode == 6'h00) begin
      unique case (bus.func_field)
        6'h20, 6'h21: alu_ctrl = CtrlAdd;
        6'h22, 6'h23: alu_ctrl = CtrlSub;
        6'h24:        alu_ctrl = CtrlAnd;
        6'h25:        alu_ctrl = CtrlOr;
        6'h26:        alu_ctrl = CtrlXor;
        6'h27:        alu_ctrl = CtrlNor;
        6'h2A:        alu_ctrl = CtrlSlt;
        6'h2B:        alu_ctrl = CtrlSltu;
        default:      alu_ctrl = CtrlNop;
      endcase
    end else begin
      unique case (bus.opcode)
        6'h23, 6'h2B, 6'h08, 6'h09: alu_ctrl = CtrlAdd;
        6'h04, 6'h05:               alu_ctrl = CtrlSub;
        6'h0C:                      alu_ctrl = CtrlAnd;
        6'h0D:                      alu_ctrl = CtrlOr;
        6'h0E:                      alu_ctrl = CtrlXor;
        6'h0A:                      alu_ctrl = CtrlSlt;
        6'h0B:                      alu_ctrl = CtrlSltu;
        default:                    alu_ctrl = CtrlNop;
      endcase
    end
  end

  assign sum  = bus.A + bus.B;
  assign diff = bus.A - bus.B;

  always_comb begin
    result_d = '0;
    unique case (alu_ctrl)
      CtrlAnd:  result_d = bus.A & bus.B;
      CtrlOr:   result_d = bus.A | bus.B;
      CtrlAdd:  result_d = sum;
      CtrlXor:  result_d = bus.A ^ bus.B;
      CtrlSub:  result_d = diff;
      CtrlSlt:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      CtrlSltu: result_d = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      CtrlNor:  result_d = ~(bus.A | bus.B);
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= (result_d == '0);
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;

`ifdef ALU_OVERFLOW_EN
  logic signed_add, signed_sub;
  logic overflow_d, overflow_q;

  // Only the trapping forms (add, addi, sub) report overflow.
  assign signed_add = ((bus.opcode == 6'h00) && (bus.func_field == 6'h20)) ||
                      (bus.opcode == 6'h08);
  assign signed_sub = (bus.opcode == 6'h00) && (bus.func_field == 6'h22);

  always_comb begin
    overflow_d = 1'b0;
    if (signed_add) begin
      overflow_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
    end else if (signed_sub) begin
      overflow_d = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`endif
endmodule

// File: tb/tb_mips_alu_top.sv
// Self-checking bench for mips_alu_top: directed cases then random ops against a reference model.
module tb_mips_alu_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mips_alu_top_if #(.WIDTH(32)) bus ();

  mips_alu_top #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24:        return a & b;
        6'h25:        return a | b;
        6'h26:        return a ^ b;
        6'h27:        return ~(a | b);
        6'h2A:        return (sa < sb) ? 32'd1 : 32'd0;
        6'h2B:        return (a < b) ? 32'd1 : 32'd0;
        default:      return 32'd0;
      endcase
    end
    case (op)
      6'h23, 6'h2B, 6'h08, 6'h09: return a + b;
      6'h04, 6'h05:               return a - b;
      6'h0C:                      return a & b;
      6'h0D:                      return a | b;
      6'h0E:                      return a ^ b;
      6'h0A:                      return (sa < sb) ? 32'd1 : 32'd0;
      6'h0B:                      return (a < b) ? 32'd1 : 32'd0;
      default:                    return 32'd0;
    endcase
  endfunction

  // Exact signed arithmetic in 64 bits, flagged when outside the 32-bit range.
  function automatic logic ref_overflow(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    if ((op == 6'h00 && fn == 6'h20) || op == 6'h08) r = sa + sb;
    else if (op == 6'h00 && fn == 6'h22) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic run_op(input string tag, input logic do_rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    rst            = do_rst;
    bus.opcode     = op;
    bus.func_field = fn;
    bus.A          = a;
    bus.B          = b;
    exp = do_rst ? 32'd0 : ref_result(op, fn, a, b);
    @(posedge clk);
    #1;
    check({tag, ".result"}, bus.result, exp);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, (exp == 32'd0)});
`ifdef ALU_OVERFLOW_EN
    check({tag, ".ovf"}, {31'd0, bus.overflow},
          {31'd0, (do_rst ? 1'b0 : ref_overflow(op, fn, a, b))});
`endif
  endtask

  logic [5:0] valid_ops [12] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h04,
                                 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B};
  logic [5:0] valid_fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'h5555_5555};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    bus.opcode = 6'h00;
    bus.func_field = 6'h20;
    bus.A = 32'h2222;
    bus.B = 32'h1111;
    #1;

    run_op("rst0", 1'b1, 6'h00, 6'h20, 32'h2222, 32'h1111);
    run_op("rst1", 1'b1, 6'h00, 6'h20, 32'h2222, 32'h1111);
    run_op("post_rst_add", 1'b0, 6'h00, 6'h20, 32'h2222, 32'h1111);
    check("add_lit", bus.result, 32'h3333);

    run_op("and", 1'b0, 6'h00, 6'h24, 32'h2222, 32'h1111);
    run_op("or", 1'b0, 6'h00, 6'h25, 32'h2222, 32'h1111);
    check("or_lit", bus.result, 32'h3333);
    run_op("nor", 1'b0, 6'h00, 6'h27, 32'h2222, 32'h1111);
    check("nor_lit", bus.result, 32'hFFFF_CCCC);
    run_op("lw", 1'b0, 6'h23, 6'h00, 32'h2222, 32'h1111);
    run_op("beq_eq", 1'b0, 6'h04, 6'h00, 32'h5555, 32'h5555);
    check("beq_eq_lit", {31'd0, bus.zero}, 32'd1);
    run_op("beq_ne", 1'b0, 6'h04, 6'h00, 32'h5555, 32'h5554);
    run_op("slt", 1'b0, 6'h00, 6'h2A, 32'h1111, 32'h2222);
    run_op("slt_neg", 1'b0, 6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1);
    check("slt_neg_lit", bus.result, 32'd1);
    run_op("sltu", 1'b0, 6'h00, 6'h2B, 32'hFFFF_FFFF, 32'h1);
    check("sltu_lit", bus.result, 32'd0);
    run_op("bad_op", 1'b0, 6'h3F, 6'h20, 32'h1234, 32'h5678);
    run_op("bad_fn", 1'b0, 6'h00, 6'h00, 32'h1234, 32'h5678);
    run_op("add_wrap", 1'b0, 6'h00, 6'h20, 32'hFFFF_FFFF, 32'h1);
    run_op("add_max", 1'b0, 6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1);
    check("add_max_lit", bus.result, 32'h8000_0000);
    run_op("sub_under", 1'b0, 6'h00, 6'h22, 32'h0, 32'h1);
    check("sub_under_lit", bus.result, 32'hFFFF_FFFF);
    run_op("sub_min", 1'b0, 6'h00, 6'h22, 32'h8000_0000, 32'h1);
    run_op("addu_max", 1'b0, 6'h00, 6'h21, 32'h7FFF_FFFF, 32'h1);
`ifdef ALU_OVERFLOW_EN
    run_op("ovf_add", 1'b0, 6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1);
    check("ovf_add_lit", {31'd0, bus.overflow}, 32'd1);
    run_op("ovf_sub", 1'b0, 6'h00, 6'h22, 32'h8000_0000, 32'h1);
    check("ovf_sub_lit", {31'd0, bus.overflow}, 32'd1);
    run_op("ovf_addu", 1'b0, 6'h00, 6'h21, 32'h7FFF_FFFF, 32'h1);
    check("ovf_addu_lit", {31'd0, bus.overflow}, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : valid_ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : valid_fns[$urandom_range(0, 9)];
      run_op("rand", ($urandom_range(0, 19) == 0), op, fn, pick_operand(), pick_operand());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_alu_top.md
Name: mips_alu_top

Overview:
- Registered MIPS-style ALU: decodes the instruction `opcode` / `func_field` into an internal 4-bit ALU control code, then performs the operation on 32-bit A and B.
- Sits in the EX stage of the datapath; result and zero flag are captured on the clock edge.
- Internally structured as a combinational ALU-control decoder, a combinational ALU core, and an output register stage.

Parameters:
- WIDTH, 32, data width of A, B and result (spec and tests assume 32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- opcode  input  6  instruction opcode field
- func_field  input  6  R-type function field; ignored when opcode != 0x00
- A  input  WIDTH  operand A (rs)
- B  input  WIDTH  operand B (rt or extended immediate, selected upstream)
- result  output  WIDTH  registered ALU result
- zero  output  1  registered flag, 1 when the registered result == 0

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, result <= 0 and zero <= 1. Reset has priority over any operation in flight; there is no partial result.
- Latency: exactly 1 cycle. Inputs are sampled at the rising edge and the outputs update at that same edge. There is no handshake; a new operation is accepted every cycle.
- ALU control decode (combinational), opcode = 0x00 (R-type), by func_field:
  - 0x20 ADD
  - 0x21 ADD (addu)
  - 0x22 SUB
  - 0x23 SUB (subu)
  - 0x24 AND
  - 0x25 OR
  - 0x26 XOR
  - 0x27 NOR
  - 0x2A SLT signed
  - 0x2B SLT unsigned
  - any other func: NOP
- ALU control decode, other opcodes:
  - 0x23 lw, 0x2B sw, 0x08 addi, 0x09 addiu: ADD
  - 0x04 beq, 0x05 bne: SUB
  - 0x0C andi: AND
  - 0x0D ori: OR
  - 0x0E xori: XOR
  - 0x0A slti: SLT signed
  - 0x0B sltiu: SLT unsigned
  - any other opcode: NOP
- Internal control codes:
  - AND=0000, OR=0001, ADD=0010, XOR=0011, SUB=0110, SLT=0111, SLTU=1000, NOR=1100
  - NOP=1111, which produces result 0.
- Arithmetic rules:
  - ADD/SUB are modulo 2^WIDTH; the carry-out is discarded.
  - SLT compares A and B as two's complement; SLTU compares them unsigned.
  - Both SLT variants produce {WIDTH-1 zeros, lt}.
- zero is computed from the next result value and registered with it, so it is always consistent with result in the same cycle.
- beq equality check: SUB of equal operands gives result 0, zero 1.
- Wrap-around cases:
  - 0x7FFFFFFF + 1 gives 0x80000000.
  - 0 - 1 gives 0xFFFFFFFF.
  - No exceptions are raised.
- No X propagation: every undefined encoding maps to NOP.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - Adds an output port `overflow` (1 bit), registered alongside result; it resets to 0.
  - For signed ADD, overflow = 1 when A and B have the same sign and the result's sign differs.
  - For signed SUB, overflow = 1 when A and B have different signs and the result's sign differs from A.
  - overflow is 0 for addu, subu, addiu, logic ops, SLT, SLTU and NOP.
  - Result is still written on overflow.
- When not defined: the port does not exist and the datapath is otherwise identical.

Test Plan:
- Reset: assert rst for 2 cycles with A=0x2222, B=0x1111, opcode 0x00, func 0x20 -> result 0, zero 1 after each edge; the first edge after rst deasserts gives result 0x3333, zero 0.
- Basic R-type: A=0x2222, B=0x1111.
  - func 0x20 -> result 0x3333, zero 0.
  - func 0x24 -> result 0x0, zero 1.
  - func 0x25 -> result 0x3333.
  - func 0x27 -> result 0xFFFFCCCC.
- Memory and branch ops:
  - opcode 0x23, A=0x2222, B=0x1111 -> result 0x3333 (ADD).
  - opcode 0x04, A=B=0x5555 -> result 0, zero 1.
  - opcode 0x04, A=0x5555, B=0x5554 -> result 1, zero 0.
- Set-less-than (func 0x2A):
  - A=0x1111, B=0x2222 -> result 1.
  - A=0xFFFFFFFF, B=0x1 -> result 1 (signed).
  - Same operands with func 0x2B -> result 0 (unsigned).
- Undefined/edge:
  - opcode 0x3F -> result 0, zero 1.
  - opcode 0x00, func 0x00 -> result 0.
  - ADD 0xFFFFFFFF + 1 -> result 0, zero 1.
  - Each check is made exactly one edge after the input change.
- With ALU_OVERFLOW_EN:
  - ADD 0x7FFFFFFF + 1 -> result 0x80000000, overflow 1.
  - SUB 0x80000000 - 1 -> overflow 1.
  - addu of the same operands -> overflow 0.
